alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal 8..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port op, input, 3 bits: operation code; 0 AND, 1 OR, 2 SUB, 3 MUL, 4 DIV, 5 ADD, 6 SLT, 7 NOP (pass A).
REQ-008 The block SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking s/z/dz valid.
REQ-010 The block SHALL have port s, output, WIDTH bits: result.
REQ-011 The block SHALL have port z, output, 1 bit: result is all zeros.
REQ-012 The block SHALL have port dz, output, 1 bit: last DIV had b = 0.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE; busy SHALL be 1 only in CALC; done SHALL be 1 only in DONE.
REQ-014 start SHALL be sampled only in IDLE or DONE; start in CALC SHALL be ignored, with no queuing.
REQ-015 On an accepted start, a, b and op SHALL be latched; later input changes SHALL NOT affect the operation in flight.
REQ-016 AND, OR, SUB, ADD, SLT, NOP and DIV-by-zero SHALL go directly to DONE, so done rises on the first edge after start is sampled (latency 1).
REQ-017 MUL and DIV with b != 0 SHALL enter CALC with an iteration counter of WIDTH, do one iteration per cycle, and go to DONE after WIDTH iterations (done at latency WIDTH+1).
REQ-018 MUL SHALL be an unsigned shift-add whose result is the low WIDTH bits of a*b.
REQ-019 DIV SHALL be an unsigned restoring division whose result is the quotient floor(a/b).
REQ-020 DIV with b = 0 SHALL give s = all ones and dz = 1; every other operation SHALL clear dz.
REQ-021 ADD and SUB SHALL wrap modulo 2^WIDTH.
REQ-022 SLT SHALL be an unsigned compare, giving s = 1 when a < b and 0 otherwise.
REQ-023 z SHALL equal (s == 0) and SHALL update together with s.
REQ-024 s, z, dz and ovf SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-025 From DONE, the FSM SHALL go to IDLE without start, or begin the new operation when start is sampled, allowing back-to-back single-cycle ops at one result per cycle.

Reset
REQ-026 While rst = 1, the FSM SHALL be IDLE, the counter 0, the latched operands 0, busy = 0, done = 0, s = 0, z = 1, dz = 0 and ovf = 0.
REQ-027 Asserting rst in CALC SHALL abort the operation, with no done pulse afterwards.
REQ-028 start sampled on the first edge after rst deasserts SHALL be accepted normally.

Configuration
REQ-029 The macro ALU_SEQ_OVF_EN SHALL control the overflow feature.
REQ-030 With ALU_SEQ_OVF_EN defined, the block SHALL add output port ovf, 1 bit, set as follows:
- ADD/SUB: two's-complement signed overflow.
- MUL: upper WIDTH bits of the full 2*WIDTH product are nonzero.
- All other ops: 0.
REQ-031 With ALU_SEQ_OVF_EN undefined, there SHALL be no ovf port and no logic for the high product half or overflow.

Verification (WIDTH = 32)
REQ-032 ADD a=5, b=7, start 1 cycle -> next edge: done=1, s=12, z=0, busy stays 0.
REQ-033 SUB a=5, b=5, then ADD a=0x7FFFFFFF, b=1 back-to-back -> s=0, z=1, then s=0x80000000 on consecutive cycles (with OVF_EN: ovf=0, then ovf=1).
REQ-034 MUL a=0x10000, b=0x10000 -> busy for 32 cycles, done at edge 33, s=0, z=1 (with OVF_EN: ovf=1); start pulsed mid-CALC is ignored.
REQ-035 DIV a=100, b=7 -> done at edge 33, s=14, dz=0; DIV a=9, b=0 -> done at edge 1, s=0xFFFFFFFF, dz=1.
REQ-036 rst pulsed at cycle 10 of a DIV -> busy=0 and s=0, z=1 immediately (async); no done follows; next ADD 1+1 gives s=2.

Source files
------------

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- small sequential ALU.
//
// Single-cycle ops (AND, OR, SUB, ADD, SLT, NOP, DIV by zero) produce their
// result on the edge that accepts start. MUL (shift-add) and DIV (restoring
// division) spend WIDTH cycles in CALC, one bit per cycle, before DONE.
//
// Parameters:
//   WIDTH  operand / result width in bits (8..64)
//
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   start  begin an operation (sampled in IDLE or DONE only)
//   a, b   operands, latched when start is accepted
//   op     0 AND, 1 OR, 2 SUB, 3 MUL, 4 DIV, 5 ADD, 6 SLT, 7 NOP (pass a)
//   busy   multi-cycle operation in progress
//   done   one-cycle pulse, s/z/dz(/ovf) just updated
//   s      result
//   z      result is zero
//   dz     last DIV had b == 0
//   ovf    overflow flag, present only when ALU_SEQ_OVF_EN is defined:
//          signed overflow for ADD/SUB, nonzero high product half for MUL
//
// Build option: define ALU_SEQ_OVF_EN to add the ovf port and its logic.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             z,
`ifdef ALU_SEQ_OVF_EN
    output logic             dz,
    output logic             ovf
`else
    output logic             dz
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
`ifdef ALU_SEQ_OVF_EN
    localparam int PW = 2 * WIDTH;
`else
    localparam int PW = WIDTH;
`endif

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;
    localparam logic [2:0] OP_ADD = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    logic [IW-1:0]    bit_idx;
    logic [PW-1:0]    prod_next;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] quick_s;
    logic             long_op;
`ifdef ALU_SEQ_OVF_EN
    logic             quick_ovf;
`endif

    // One iteration of the multi-cycle datapath. Both MUL and DIV walk the
    // latched operand bits MSB first, indexed by the counter (cnt counts
    // WIDTH..1, so cnt-1 is the bit being processed). MUL is a Horner-style
    // shift-add: shift the partial product left, add a when the b bit is set.
    // DIV brings the next a bit into the remainder and keeps the trial
    // subtraction only when it does not go negative.
    always_comb begin
        bit_idx   = IW'(cnt - CW'(1));
        prod_next = (prod << 1) + (b_q[bit_idx] ? PW'(a_q) : PW'(0));
        rem_sh    = {rem, a_q[bit_idx]};
        rem_diff  = rem_sh - {1'b0, b_q};
        if (rem_diff[WIDTH]) begin
            rem_next = rem_sh[WIDTH-1:0];
            quo_next = quo << 1;
        end else begin
            rem_next = rem_diff[WIDTH-1:0];
            quo_next = (quo << 1) | WIDTH'(1);
        end
    end

    // Results of the ops that finish on the accepting edge, computed straight
    // from the inputs since they are registered on that same edge.
    always_comb begin
        sum     = a + b;
        dif     = a - b;
        long_op = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
        case (op)
            OP_AND:  quick_s = a & b;
            OP_OR:   quick_s = a | b;
            OP_SUB:  quick_s = dif;
            OP_ADD:  quick_s = sum;
            OP_SLT:  quick_s = (a < b) ? WIDTH'(1) : '0;
            OP_DIV:  quick_s = '1;
            default: quick_s = a;
        endcase
`ifdef ALU_SEQ_OVF_EN
        case (op)
            OP_ADD:  quick_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  quick_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            default: quick_ovf = 1'b0;
        endcase
`endif
    end

    // Control FSM with registered busy/done and result registers. IDLE and
    // DONE behave the same towards start, which is what lets single-cycle
    // ops stream at one result per clock. The result registers are written
    // only when entering DONE, so they hold between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            prod  <= '0;
            quo   <= '0;
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            z     <= 1'b1;
            dz    <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op;
                        if (long_op) begin
                            state <= CALC;
                            busy  <= 1'b1;
                            cnt   <= CW'(WIDTH);
                            prod  <= '0;
                            quo   <= '0;
                            rem   <= '0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            s     <= quick_s;
                            z     <= (quick_s == '0);
                            dz    <= (op == OP_DIV);
`ifdef ALU_SEQ_OVF_EN
                            ovf   <= quick_ovf;
`endif
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (op_q == OP_MUL) begin
                        prod <= prod_next;
                    end else begin
                        quo <= quo_next;
                        rem <= rem_next;
                    end
                    // The last iteration's result goes straight to s.
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        dz    <= 1'b0;
                        if (op_q == OP_MUL) begin
                            s <= prod_next[WIDTH-1:0];
                            z <= (prod_next[WIDTH-1:0] == '0);
`ifdef ALU_SEQ_OVF_EN
                            ovf <= |prod_next[PW-1:WIDTH];
`endif
                        end else begin
                            s <= quo_next;
                            z <= (quo_next == '0);
`ifdef ALU_SEQ_OVF_EN
                            ovf <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq at WIDTH = 32.
// A cycle-level behavioural model (plain arithmetic, a countdown of the
// remaining busy cycles) is checked against the DUT on every falling edge;
// directed tests add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 32;

    localparam logic [2:0] AND_OP = 3'd0;
    localparam logic [2:0] OR_OP  = 3'd1;
    localparam logic [2:0] SUB_OP = 3'd2;
    localparam logic [2:0] MUL_OP = 3'd3;
    localparam logic [2:0] DIV_OP = 3'd4;
    localparam logic [2:0] ADD_OP = 3'd5;
    localparam logic [2:0] SLT_OP = 3'd6;
    localparam logic [2:0] NOP_OP = 3'd7;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         z;
    logic         dz;
`ifdef ALU_SEQ_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .op    (op),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .z     (z),
`ifdef ALU_SEQ_OVF_EN
        .dz    (dz),
        .ovf   (ovf)
`else
        .dz    (dz)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         dz;
        logic         ovf;
        logic         long_op;
    } res_t;

    // What one operation must produce, from plain arithmetic.
    function automatic res_t modelOp(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t        r;
        logic [63:0] full;
        longint      exact;
        r = '0;
        case (o)
            AND_OP: r.s = x & y;
            OR_OP:  r.s = x | y;
            SUB_OP: begin
                r.s   = x - y;
                exact = longint'($signed(x)) - longint'($signed(y));
                r.ovf = (exact != longint'($signed(r.s)));
            end
            ADD_OP: begin
                r.s   = x + y;
                exact = longint'($signed(x)) + longint'($signed(y));
                r.ovf = (exact != longint'($signed(r.s)));
            end
            MUL_OP: begin
                full      = 64'(x) * 64'(y);
                r.s       = full[W-1:0];
                r.ovf     = (full[63:W] != '0);
                r.long_op = 1'b1;
            end
            DIV_OP: begin
                if (y == '0) begin
                    r.s  = '1;
                    r.dz = 1'b1;
                end else begin
                    r.s       = x / y;
                    r.long_op = 1'b1;
                end
            end
            SLT_OP: r.s = (x < y) ? 32'd1 : 32'd0;
            default: r.s = x;
        endcase
        return r;
    endfunction

    // Model timing: single-cycle ops publish on the accepting edge; long ops
    // publish W edges later and ignore start meanwhile.
    logic [W-1:0] exp_s    = '0;
    logic         exp_z    = 1'b1;
    logic         exp_dz   = 1'b0;
    logic         exp_ovf  = 1'b0;
    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;
    res_t         pend     = '0;
    int           remaining = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_s     <= '0;
            exp_z     <= 1'b1;
            exp_dz    <= 1'b0;
            exp_ovf   <= 1'b0;
            exp_busy  <= 1'b0;
            exp_done  <= 1'b0;
            remaining <= 0;
        end else if (remaining > 0) begin
            remaining <= remaining - 1;
            if (remaining == 1) begin
                exp_s    <= pend.s;
                exp_z    <= (pend.s == '0);
                exp_dz   <= pend.dz;
                exp_ovf  <= pend.ovf;
                exp_busy <= 1'b0;
                exp_done <= 1'b1;
            end else begin
                exp_busy <= 1'b1;
                exp_done <= 1'b0;
            end
        end else if (start) begin
            if (modelOp(op, a, b).long_op) begin
                pend      <= modelOp(op, a, b);
                remaining <= W;
                exp_busy  <= 1'b1;
                exp_done  <= 1'b0;
            end else begin
                exp_s    <= modelOp(op, a, b).s;
                exp_z    <= (modelOp(op, a, b).s == '0);
                exp_dz   <= modelOp(op, a, b).dz;
                exp_ovf  <= modelOp(op, a, b).ovf;
                exp_busy <= 1'b0;
                exp_done <= 1'b1;
            end
        end else begin
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        checkOutput("cyc busy", 64'(busy), 64'(exp_busy));
        checkOutput("cyc done", 64'(done), 64'(exp_done));
        checkOutput("cyc s",    64'(s),    64'(exp_s));
        checkOutput("cyc z",    64'(z),    64'(exp_z));
        checkOutput("cyc dz",   64'(dz),   64'(exp_dz));
`ifdef ALU_SEQ_OVF_EN
        checkOutput("cyc ovf",  64'(ovf),  64'(exp_ovf));
`endif
    end

    task automatic applyStimulus(input logic st, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = st;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Called right after start is driven. Returns the edge number at which
    // done was seen (1 = accepting edge) and how many of those edges left
    // busy high. Optionally pulses start (ADD 1+1) at edge pulse_at.
    task automatic waitDone(input int limit, input int pulse_at, output int cycles, output int busy_cnt);
        cycles   = -1;
        busy_cnt = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (i == pulse_at) begin
                start = 1'b1;
                op    = ADD_OP;
                a     = 32'd1;
                b     = 32'd1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                cycles = i;
                break;
            end
        end
        if (cycles < 0) checkOutput("done timeout", 64'd0, 64'd1);
        start = 1'b0;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int cyc;
        int bcnt;
        int dcnt;

        vecs[0]  = '{AND_OP, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
        vecs[1]  = '{OR_OP,  32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF};
        vecs[2]  = '{SLT_OP, 32'd3,         32'd5,         32'd1};
        vecs[3]  = '{SLT_OP, 32'd5,         32'd3,         32'd0};
        vecs[4]  = '{SLT_OP, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[5]  = '{NOP_OP, 32'hDEAD_BEEF, 32'h0000_1234, 32'hDEAD_BEEF};
        vecs[6]  = '{SUB_OP, 32'd0,         32'd1,         32'hFFFF_FFFF};
        vecs[7]  = '{ADD_OP, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[8]  = '{MUL_OP, 32'd7,         32'd6,         32'd42};
        vecs[9]  = '{DIV_OP, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF};
        vecs[10] = '{DIV_OP, 32'd6,         32'd7,         32'd0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        op    = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset s",    64'(s),    64'd0);
        checkOutput("reset z",    64'(z),    64'd1);
        checkOutput("reset dz",   64'(dz),   64'd0);
        rst = 1'b0;

        // ADD 5+7: done on the accepting edge, never busy.
        applyStimulus(1'b1, ADD_OP, 32'd5, 32'd7);
        waitDone(5, 0, cyc, bcnt);
        checkOutput("add latency", 64'(cyc),  64'd1);
        checkOutput("add busy",    64'(bcnt), 64'd0);
        checkOutput("add s",       64'(s),    64'd12);
        checkOutput("add z",       64'(z),    64'd0);

        // SUB 5-5 then ADD 0x7FFFFFFF+1 back to back.
        applyStimulus(1'b1, SUB_OP, 32'd5, 32'd5);
        applyStimulus(1'b1, ADD_OP, 32'h7FFF_FFFF, 32'd1);
        checkOutput("b2b sub done", 64'(done), 64'd1);
        checkOutput("b2b sub s",    64'(s),    64'd0);
        checkOutput("b2b sub z",    64'(z),    64'd1);
`ifdef ALU_SEQ_OVF_EN
        checkOutput("b2b sub ovf",  64'(ovf),  64'd0);
`endif
        applyStimulus(1'b0, NOP_OP, 32'd0, 32'd0);
        checkOutput("b2b add done", 64'(done), 64'd1);
        checkOutput("b2b add s",    64'(s),    64'h8000_0000);
        checkOutput("b2b add z",    64'(z),    64'd0);
`ifdef ALU_SEQ_OVF_EN
        checkOutput("b2b add ovf",  64'(ovf),  64'd1);
`endif

        // MUL 0x10000*0x10000 with a start pulse mid-CALC that must be ignored.
        applyStimulus(1'b1, MUL_OP, 32'h0001_0000, 32'h0001_0000);
        waitDone(60, 10, cyc, bcnt);
        checkOutput("mul latency", 64'(cyc),  64'd33);
        checkOutput("mul busy",    64'(bcnt), 64'd32);
        checkOutput("mul s",       64'(s),    64'd0);
        checkOutput("mul z",       64'(z),    64'd1);
`ifdef ALU_SEQ_OVF_EN
        checkOutput("mul ovf",     64'(ovf),  64'd1);
`endif

        // DIV 100/7 and DIV 9/0.
        applyStimulus(1'b1, DIV_OP, 32'd100, 32'd7);
        waitDone(60, 0, cyc, bcnt);
        checkOutput("div latency", 64'(cyc), 64'd33);
        checkOutput("div s",       64'(s),   64'd14);
        checkOutput("div dz",      64'(dz),  64'd0);
        applyStimulus(1'b1, DIV_OP, 32'd9, 32'd0);
        waitDone(5, 0, cyc, bcnt);
        checkOutput("div0 latency", 64'(cyc), 64'd1);
        checkOutput("div0 s",       64'(s),   64'hFFFF_FFFF);
        checkOutput("div0 dz",      64'(dz),  64'd1);

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone(60, 0, cyc, bcnt);
            checkOutput($sformatf("vec%0d s", i), 64'(s), 64'(vecs[i].s));
            checkOutput($sformatf("vec%0d dz", i), 64'(dz), 64'd0);
        end

        // Abort a DIV with reset after 10 cycles; no done may follow.
        applyStimulus(1'b1, DIV_OP, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("abort busy before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort s",    64'(s),    64'd0);
        checkOutput("abort z",    64'(z),    64'd1);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        checkOutput("abort no done", 64'(dcnt), 64'd0);

        // Start on the very first edge after reset release.
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        op    = ADD_OP;
        a     = 32'd1;
        b     = 32'd1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("post-rst done", 64'(done), 64'd1);
        checkOutput("post-rst s",    64'(s),    64'd2);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
